// File: rtl/elastic_config_loader.sv
// elastic_config_loader: streams packed per-PE context records into the ElasticPE
// config memories over a broadcast config bus with one-hot per-PE write strobes,
// then pulses start_exec once every write has landed.
module elastic_config_loader #(
  parameter int unsigned PE_NUM                  = 16,
  parameter int unsigned CONTEXT_SIZE            = 16,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 4,
  parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
  parameter int unsigned NEIGHBOR_PE_NUM         = 4,
  parameter int unsigned OPERATION_BIT_LENGTH    = 4,
  parameter int unsigned DATA_WIDTH              = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  load_start,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    load_context_max_id,
  input  logic [2*INPUT_NUM_BIT_LENGTH+NEIGHBOR_PE_NUM+OPERATION_BIT_LENGTH+DATA_WIDTH-1:0] rec_data,
  input  logic                                  rec_valid,
  output logic                                  rec_stop,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]       config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]       config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]            config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
  output logic [DATA_WIDTH-1:0]                 config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
  output logic [PE_NUM-1:0]                     write_config_data,
  output logic                                  start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
  output logic                                  busy,
  output logic                                  load_error
);

  localparam int unsigned CTX_W    = CONTEXT_SIZE_BIT_LENGTH;
  localparam int unsigned PE_IDX_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int unsigned INW      = INPUT_NUM_BIT_LENGTH;
  localparam int unsigned NBW      = NEIGHBOR_PE_NUM;
  localparam int unsigned OPW      = OPERATION_BIT_LENGTH;
  localparam int unsigned OP_LSB   = DATA_WIDTH;
  localparam int unsigned MASK_LSB = OP_LSB + OPW;
  localparam int unsigned IN2_LSB  = MASK_LSB + NBW;
  localparam int unsigned IN1_LSB  = IN2_LSB + INW;

  // DRAIN separates the final write strobe from start_exec by one cycle
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_START = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [PE_IDX_W-1:0]   r_pe;
  logic [CTX_W-1:0]      r_ctx;
  logic                  w_max_ok;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_xfer;
  logic                  w_last_pe;
  logic                  w_last_rec;
  logic                  w_rec_stop;
  logic                  w_busy;
  logic                  w_start;

  // Load request qualification and record handshake decode
  assign w_max_ok   = ({1'b0, load_context_max_id} < (CTX_W+1)'(CONTEXT_SIZE));
  assign w_accept   = (r_state == S_IDLE) && load_start && w_max_ok;
  assign w_reject   = (r_state == S_IDLE) && load_start && !w_max_ok;
  assign w_xfer     = (r_state == S_LOAD) && rec_valid;
  assign w_last_pe  = (r_pe == PE_IDX_W'(PE_NUM - 1));
  assign w_last_rec = w_last_pe && (r_ctx == mapping_context_max_id);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)              w_next_state = S_LOAD;
      S_LOAD:  if (w_xfer && w_last_rec)  w_next_state = S_DRAIN;
      S_DRAIN:                            w_next_state = S_START;
      S_START:                            w_next_state = S_IDLE;
      default:                            w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_rec_stop = 1'b1;
    w_busy     = 1'b1;
    w_start    = 1'b0;
    case (r_state)
      S_IDLE:  w_busy     = 1'b0;
      S_LOAD:  w_rec_stop = 1'b0;
      S_START: w_start    = 1'b1;
      default: ;
    endcase
  end

  assign rec_stop   = w_rec_stop;
  assign busy       = w_busy;
  assign start_exec = w_start;

  // PE-major record position counters and latched mapping size
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pe                   <= '0;
      r_ctx                  <= '0;
      mapping_context_max_id <= '0;
      load_error             <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pe                   <= '0;
        r_ctx                  <= '0;
        mapping_context_max_id <= load_context_max_id;
        load_error             <= 1'b0;
      end else begin
        if (w_reject) load_error <= 1'b1;
        if (w_xfer) begin
          if (w_last_pe) begin
            r_pe  <= '0;
            r_ctx <= r_ctx + CTX_W'(1);
          end else begin
            r_pe  <= r_pe + PE_IDX_W'(1);
          end
        end
      end
    end
  end

  // Broadcast config bus: fields hold between writes, strobe qualifies them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      config_input_PE_index_1 <= '0;
      config_input_PE_index_2 <= '0;
      config_output_PE_index  <= '0;
      config_op               <= '0;
      config_const_data       <= '0;
      config_index            <= '0;
      write_config_data       <= '0;
    end else begin
      write_config_data <= '0;
      if (w_xfer) begin
        config_input_PE_index_1 <= rec_data[IN1_LSB +: INW];
        config_input_PE_index_2 <= rec_data[IN2_LSB +: INW];
        config_output_PE_index  <= rec_data[MASK_LSB +: NBW];
        config_op               <= rec_data[OP_LSB +: OPW];
        config_const_data       <= rec_data[0 +: DATA_WIDTH];
        config_index            <= r_ctx;
        write_config_data       <= PE_NUM'(1) << r_pe;
      end
    end
  end

endmodule

// File: tb/tb_elastic_config_loader.sv
// Directed bench for elastic_config_loader with PE_NUM=4 and a 5-bit context id
// so that an out-of-range max id (16) can be presented.
module tb_elastic_config_loader;

  localparam int unsigned PE_NUM = 4;
  localparam int unsigned CTX_W  = 5;
  localparam int unsigned REC_W  = 46;

  logic              clk;
  logic              reset;
  logic              load_start;
  logic [CTX_W-1:0]  load_context_max_id;
  logic [REC_W-1:0]  rec_data;
  logic              rec_valid;
  logic              rec_stop;
  logic [2:0]        cfg_in1;
  logic [2:0]        cfg_in2;
  logic [3:0]        cfg_out;
  logic [3:0]        cfg_op;
  logic [31:0]       cfg_const;
  logic [CTX_W-1:0]  config_index;
  logic [PE_NUM-1:0] write_config_data;
  logic              start_exec;
  logic [CTX_W-1:0]  mapping_context_max_id;
  logic              busy;
  logic              load_error;

  int checks = 0;
  int errors = 0;

  elastic_config_loader #(
    .PE_NUM(PE_NUM), .CONTEXT_SIZE(16), .CONTEXT_SIZE_BIT_LENGTH(CTX_W),
    .INPUT_NUM_BIT_LENGTH(3), .NEIGHBOR_PE_NUM(4), .OPERATION_BIT_LENGTH(4),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .load_context_max_id(load_context_max_id), .rec_data(rec_data),
    .rec_valid(rec_valid), .rec_stop(rec_stop),
    .config_input_PE_index_1(cfg_in1), .config_input_PE_index_2(cfg_in2),
    .config_output_PE_index(cfg_out), .config_op(cfg_op),
    .config_const_data(cfg_const), .config_index(config_index),
    .write_config_data(write_config_data), .start_exec(start_exec),
    .mapping_context_max_id(mapping_context_max_id), .busy(busy),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input int n, input bit special);
    if (special && n == 2) return {3'd2, 3'd5, 4'b1010, 4'h7, 32'hDEADBEEF};
    return {3'(n), 3'(n + 1), 4'(1 << (n % 4)), 4'(n), 32'hC0DE0000 + 32'(n)};
  endfunction

  // One full load; record 0 is offered in the load_start cycle and must not be taken
  task automatic do_load(input int max_id, input bit toggle, input bit special, input int repulse_at);
    int total;
    logic [REC_W-1:0] r;
    total = (max_id + 1) * PE_NUM;
    load_start = 1'b1;
    load_context_max_id = CTX_W'(max_id);
    rec_valid = 1'b1;
    rec_data = mk_rec(0, special);
    step();
    load_start = 1'b0;
    check("busy_on_load", 64'(busy), 64'd1);
    check("stop_low_in_load", 64'(rec_stop), 64'd0);
    check("no_accept_in_idle", 64'(write_config_data), 64'd0);
    check("max_id_latched", 64'(mapping_context_max_id), 64'(max_id));
    check("error_cleared", 64'(load_error), 64'd0);
    for (int n = 0; n < total; n++) begin
      if (toggle) begin
        rec_valid = 1'b0;
        step();
        check("stall_no_strobe", 64'(write_config_data), 64'd0);
        check("stall_stop_low", 64'(rec_stop), 64'd0);
      end
      r = mk_rec(n, special);
      rec_valid = 1'b1;
      rec_data = r;
      if (n == repulse_at) begin
        load_start = 1'b1;
        load_context_max_id = CTX_W'(max_id + 1);
      end
      step();
      load_start = 1'b0;
      load_context_max_id = CTX_W'(max_id);
      check("strobe", 64'(write_config_data), 64'(1 << (n % PE_NUM)));
      check("index", 64'(config_index), 64'(n / PE_NUM));
      check("fields", 64'({cfg_in1, cfg_in2, cfg_out, cfg_op, cfg_const}), 64'(r));
      check("no_early_start", 64'(start_exec), 64'd0);
      if (n == repulse_at) check("repulse_max_id", 64'(mapping_context_max_id), 64'(max_id));
      if (n < total - 1) check("stop_low_mid", 64'(rec_stop), 64'd0);
    end
    rec_valid = 1'b0;
    step();
    check("start_pulse", 64'(start_exec), 64'd1);
    check("start_no_strobe", 64'(write_config_data), 64'd0);
    step();
    check("start_single", 64'(start_exec), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    check("stop_high_after", 64'(rec_stop), 64'd1);
    step();
    check("no_second_start", 64'(start_exec), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    load_start = 1'b0;
    load_context_max_id = '0;
    rec_data = '0;
    rec_valid = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stop", 64'(rec_stop), 64'd1);
    check("rst_strobe", 64'(write_config_data), 64'd0);
    check("rst_start", 64'(start_exec), 64'd0);
    check("rst_err", 64'(load_error), 64'd0);
    check("rst_maxid", 64'(mapping_context_max_id), 64'd0);
    reset = 1'b0;
    step();

    // Back-to-back stream, then toggling valid, then the field-exact record
    do_load(1, 1'b0, 1'b0, -1);
    do_load(1, 1'b1, 1'b0, -1);
    do_load(0, 1'b0, 1'b1, -1);

    // Out-of-range max id is rejected and flagged
    load_start = 1'b1;
    load_context_max_id = CTX_W'(16);
    step();
    load_start = 1'b0;
    check("bad_busy", 64'(busy), 64'd0);
    check("bad_err", 64'(load_error), 64'd1);
    check("bad_stop", 64'(rec_stop), 64'd1);
    step();
    check("bad_err_sticky", 64'(load_error), 64'd1);
    do_load(0, 1'b0, 1'b0, -1);

    // Asynchronous reset after 3 of 8 records
    load_start = 1'b1;
    load_context_max_id = CTX_W'(1);
    step();
    load_start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      rec_valid = 1'b1;
      rec_data = mk_rec(n, 1'b0);
      step();
    end
    check("pre_rst_strobe", 64'(write_config_data), 64'd4);
    #2 reset = 1'b1;
    #1;
    check("arst_strobe", 64'(write_config_data), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_stop", 64'(rec_stop), 64'd1);
    check("arst_start", 64'(start_exec), 64'd0);
    check("arst_index", 64'(config_index), 64'd0);
    check("arst_const", 64'(cfg_const), 64'd0);
    rec_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("post_rst_start", 64'(start_exec), 64'd0);
    do_load(1, 1'b0, 1'b0, -1);

    // load_start re-pulsed mid-load is ignored
    do_load(1, 1'b0, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
